// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for a 5-stage pipeline. Shadows the
// register tags of the E, M and W stages and derives the operand-forwarding
// selects, the load-use interlock and the taken-branch flushes.
module hazard_scoreboard #(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rs1_d,
   input  logic [REG_W-1:0] rs2_d,
   input  logic [REG_W-1:0] rd_d,
   input  logic             reg_write_d,
   input  logic             load_d,
   input  logic             pc_src_e,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_d,
   output logic             flush_e
);

   localparam logic [1:0] FwdReg = 2'b00;
   localparam logic [1:0] FwdWb  = 2'b01;
   localparam logic [1:0] FwdMem = 2'b10;

   // Execute-stage tags
   logic [REG_W-1:0] rs1_e_q, rs1_e_d;
   logic [REG_W-1:0] rs2_e_q, rs2_e_d;
   logic [REG_W-1:0] rd_e_q, rd_e_d;
   logic             reg_write_e_q, reg_write_e_d;
   logic             load_e_q, load_e_d;
   // Memory-stage tags
   logic [REG_W-1:0] rd_m_q, rd_m_d;
   logic             reg_write_m_q, reg_write_m_d;
   // Writeback-stage tags
   logic [REG_W-1:0] rd_w_q, rd_w_d;
   logic             reg_write_w_q, reg_write_w_d;

   logic             lw_stall;

   // MEM beats WB; x0 is hard-wired zero so it is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
      logic [1:0] sel;
      sel = FwdReg;
      if (rs != '0) begin
         if (reg_write_m_q && (rd_m_q == rs)) begin
            sel = FwdMem;
         end else if (reg_write_w_q && (rd_w_q == rs)) begin
            sel = FwdWb;
         end
      end
      return sel;
   endfunction

   // Forwarding selects, load-use interlock and stall/flush outputs
   always_comb begin
      lw_stall = load_e_q && (rd_e_q != '0) &&
                 ((rd_e_q == rs1_d) || (rd_e_q == rs2_d)) && !pc_src_e;
      forward_a_e = fwd_sel(rs1_e_q);
      forward_b_e = fwd_sel(rs2_e_q);
      stall_f     = lw_stall;
      stall_d     = lw_stall;
      flush_d     = pc_src_e;
      flush_e     = lw_stall || pc_src_e;
      if (reset) begin
         forward_a_e = FwdReg;
         forward_b_e = FwdReg;
         stall_f     = 1'b0;
         stall_d     = 1'b0;
         flush_d     = 1'b1;
         flush_e     = 1'b1;
      end
   end

   // Next-state: tags shift one stage per clock; a flush injects a bubble into E
   always_comb begin
      rs1_e_d       = rs1_d;
      rs2_e_d       = rs2_d;
      rd_e_d        = rd_d;
      reg_write_e_d = reg_write_d;
      load_e_d      = load_d;
      if (flush_e) begin
         rs1_e_d       = '0;
         rs2_e_d       = '0;
         rd_e_d        = '0;
         reg_write_e_d = 1'b0;
         load_e_d      = 1'b0;
      end
      rd_m_d        = rd_e_q;
      reg_write_m_d = reg_write_e_q;
      rd_w_d        = rd_m_q;
      reg_write_w_d = reg_write_m_q;
   end

   // Stage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rs1_e_q       <= '0;
         rs2_e_q       <= '0;
         rd_e_q        <= '0;
         reg_write_e_q <= 1'b0;
         load_e_q      <= 1'b0;
         rd_m_q        <= '0;
         reg_write_m_q <= 1'b0;
         rd_w_q        <= '0;
         reg_write_w_q <= 1'b0;
      end else begin
         rs1_e_q       <= rs1_e_d;
         rs2_e_q       <= rs2_e_d;
         rd_e_q        <= rd_e_d;
         reg_write_e_q <= reg_write_e_d;
         load_e_q      <= load_e_d;
         rd_m_q        <= rd_m_d;
         reg_write_m_q <= reg_write_m_d;
         rd_w_q        <= rd_w_d;
         reg_write_w_q <= reg_write_w_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Outputs are packed as
// {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}.
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       reg_write_d, load_d, pc_src_e;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, flush_d, flush_e;

   int n_checks;
   int n_fails;

   hazard_scoreboard #(.REG_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd_d        (rd_d),
      .reg_write_d (reg_write_d),
      .load_d      (load_d),
      .pc_src_e    (pc_src_e),
      .forward_a_e (forward_a_e),
      .forward_b_e (forward_b_e),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .flush_e     (flush_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive Decode fields; pc_src_e is driven separately
   task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic ld);
      rs1_d       = rs1;
      rs2_d       = rs2;
      rd_d        = rd;
      reg_write_d = rw;
      load_d      = ld;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      pc_src_e = 1'b0;
      reset    = 1'b1;

      // Reset held for two edges with random Decode inputs
      for (int i = 0; i < 2; i++) begin
         dec(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
         check("reset_forced", outs(), 8'b0000_0011);
         step();
      end
      reset = 1'b0;
      dec(0, 0, 0, 0, 0);
      check("after_reset", outs(), 8'b0000_0000);

      // MEM forward: add x5, then consumer rs1=5 rs2=6
      dec(0, 0, 5, 1, 0);
      check("mem_fwd_producer", outs(), 8'b0000_0000);
      step();
      dec(5, 6, 8, 1, 0);
      check("mem_fwd_consumer_in_d", outs(), 8'b0000_0000);
      step();
      dec(0, 0, 0, 0, 0);
      check("mem_fwd_a", outs(), 8'b1000_0000);
      step();

      // WB forward: x7 writer, filler, consumer rs1=rs2=7
      dec(0, 0, 7, 1, 0);
      step();
      dec(0, 0, 0, 0, 0);
      step();
      dec(7, 7, 9, 0, 0);
      step();
      dec(0, 0, 0, 0, 0);
      check("wb_fwd_both", outs(), 8'b0101_0000);

      // Priority: x7 writers in M and W, consumer in E
      dec(0, 0, 7, 1, 0);
      step();
      dec(0, 0, 7, 1, 0);
      step();
      dec(7, 7, 9, 0, 0);
      step();
      dec(0, 0, 0, 0, 0);
      check("mem_over_wb", outs(), 8'b1010_0000);
      step();

      // x0: load to x0 must neither stall nor forward
      dec(0, 0, 0, 1, 1);
      step();
      dec(0, 0, 0, 0, 0);
      check("x0_no_stall", outs(), 8'b0000_0000);
      step();
      check("x0_no_fwd", outs(), 8'b0000_0000);
      step();

      // Load-use: load x3, consumer rs2=3 held in Decode while stalled
      dec(0, 0, 3, 1, 1);
      step();
      dec(4, 3, 10, 1, 0);
      check("lu_stall", outs(), 8'b0000_1101);
      step();
      check("lu_bubble", outs(), 8'b0000_0000);
      step();
      dec(0, 0, 0, 0, 0);
      check("lu_wb_fwd_b", outs(), 8'b0001_0000);
      step();

      // Branch wins over load-use
      dec(0, 0, 3, 1, 1);
      step();
      dec(3, 0, 11, 1, 0);
      pc_src_e = 1'b1;
      #1;
      check("br_over_lu", outs(), 8'b0000_0011);
      step();
      pc_src_e = 1'b0;
      dec(0, 0, 0, 0, 0);
      check("br_bubble", outs(), 8'b0000_0000);
      step();

      // Reset mid-operation discards in-flight tags
      dec(0, 0, 5, 1, 0);
      step();
      dec(5, 0, 12, 1, 0);
      step();
      dec(0, 0, 0, 0, 0);
      check("pre_reset_fwd", outs(), 8'b1000_0000);
      reset = 1'b1;
      #1;
      check("mid_reset_forced", outs(), 8'b0000_0011);
      step();
      reset = 1'b0;
      #1;
      check("mid_reset_cleared", outs(), 8'b0000_0000);
      step();
      check("mid_reset_cleared2", outs(), 8'b0000_0000);

      // Back-to-back loads to x3; stall only behind the second
      dec(0, 0, 3, 1, 1);
      step();
      dec(0, 0, 3, 1, 1);
      check("b2b_no_stall", outs(), 8'b0000_0000);
      step();
      dec(3, 0, 13, 1, 0);
      check("b2b_stall", outs(), 8'b0000_1101);
      step();
      check("b2b_bubble", outs(), 8'b0000_0000);
      step();
      dec(0, 0, 0, 0, 0);
      check("b2b_wb_fwd_a", outs(), 8'b0100_0000);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Keeps its own shadow copy of destination/source register tags for the E, M and W stages, fed from decode-stage fields each cycle.
- Generates the 2-bit select codes for the two 3-input operand-forwarding muxes in Execute.
- Generates the stall and flush controls for Fetch, Decode and Execute (load-use interlock, taken-branch flush).

Parameters:
- REG_W, 5, register-index width (32 architectural registers; x0 hard-wired zero).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1_d  input  REG_W  source register 1 of the instruction in Decode.
- rs2_d  input  REG_W  source register 2 of the instruction in Decode.
- rd_d  input  REG_W  destination register of the instruction in Decode.
- reg_write_d  input  1  Decode instruction writes the register file.
- load_d  input  1  Decode instruction is a load (result from data memory).
- pc_src_e  input  1  branch/jump in Execute is taken.
- forward_a_e  output  2  select for operand-A mux: 00 reg file, 01 result_w, 10 alu_result_m.
- forward_b_e  output  2  select for operand-B mux, same encoding.
- stall_f  output  1  hold PC.
- stall_d  output  1  hold the F/D pipeline register.
- flush_d  output  1  clear the F/D pipeline register.
- flush_e  output  1  clear the D/E pipeline register.

Behaviour:
- Internal stage registers:
  - E: rs1_e, rs2_e, rd_e, reg_write_e, load_e.
  - M: rd_m, reg_write_m.
  - W: rd_w, reg_write_w.
- Each rising edge, with reset low:
  - W takes M.
  - M takes E.
  - E takes the Decode fields, or an all-zero bubble when flush_e is 1.
- Reset (sync): all internal registers cleared to 0 on the edge.
  - While reset is high, outputs are forced: forward_a_e = forward_b_e = 00, stall_f = stall_d = 0, flush_d = flush_e = 1.
  - Reset asserted mid-operation discards all in-flight tags. The first cycle after reset shows no forwarding.
- Forwarding (combinational from internal state; evaluated identically for A/rs1_e and B/rs2_e):
  - 10 if reg_write_m and rd_m == rs_e and rs_e != 0.
  - else 01 if reg_write_w and rd_w == rs_e and rs_e != 0.
  - else 00.
  - MEM has priority over WB when both match.
  - x0 is never forwarded.
  - Code 11 is never produced.
- Load-use interlock, lw_stall:
  - lw_stall = load_e & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)) & ~pc_src_e.
- Outputs (reset low):
  - stall_f = lw_stall; stall_d = lw_stall.
  - flush_d = pc_src_e.
  - flush_e = lw_stall | pc_src_e.
- Stall behaviour: exactly one bubble is inserted into E. The next cycle, the load is in M, so lw_stall deasserts, and the dependent instruction receives the loaded value via WB forwarding (01) one cycle later.
- Simultaneous taken branch and load-use: pc_src_e wins.
  - stall_f = stall_d = 0; flush_d = flush_e = 1.
  - The dependent instruction is squashed, so no stall is needed.
- Back-to-back loads to the same rd: each is tracked independently. A stall occurs only when a dependent instruction sits directly behind a load.
- No latency on outputs. All outputs are combinational from the current state and Decode inputs. State advances one stage per clock and never stalls internally.

Test Plan:
- Reset: hold reset 2 cycles with random Decode inputs.
  - Required during reset: forward_a_e = forward_b_e = 00, stall_f = 0, flush_d = flush_e = 1.
  - Required on the first cycle after release: all outputs 0.
- MEM forward: issue add x5 (rd_d = 5, reg_write_d = 1), then an instruction with rs1_d = 5, rs2_d = 6.
  - Required when the consumer is in E: forward_a_e = 10, forward_b_e = 00.
- WB forward and priority:
  - x7 writer, filler, then a consumer with rs1 = rs2 = 7 → both selects 01.
  - Writers to x7 in both M and W → both selects 10.
- x0 never forwarded: writer with rd_d = 0, reg_write_d = 1, followed by a consumer with rs1_d = 0 → forward_a_e = 00, no stall.
- Load-use: load x3 (load_d = 1, rd_d = 3), then a consumer with rs2_d = 3.
  - Cycle 1: stall_f = stall_d = flush_e = 1.
  - Next cycle: stall deasserts, bubble in E.
  - Following cycle: forward_b_e = 01.
- Branch vs load-use: load x3 in E with rs1_d = 3 and pc_src_e = 1 in the same cycle → stall_f = 0, flush_d = flush_e = 1. After that edge, E holds a bubble (no forwarding).
